// File: rtl/clk_freq_meter.sv
// clk_freq_meter: gated-window frequency counter.
// Counts rising edges of an asynchronous input over a window of
// GATE_CYCLES system clocks and reports the result with a one-cycle
// valid strobe. The count saturates at all-ones, and overflow reports
// that saturation.
module clk_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             meas_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GATE = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             s1, s2, s3;
    logic             rise;
    logic [1:0]       state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_next;
    logic             sat, sat_next;
    logic             window_end;
    logic             restart;

    // Two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= meas_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturating next value of the edge counter; the sat flag records a lost edge
    always_comb begin
        edge_next = edge_cnt;
        sat_next  = sat;
        if (rise) begin
            if (edge_cnt == CNT_MAX) sat_next  = 1'b1;
            else                     edge_next = edge_cnt + 1'b1;
        end
    end

    // The last GATE cycle still counts its rise, so the result is taken from edge_next
    assign window_end = (state == S_GATE) && (gate_cnt == '0);
    assign restart    = ((state == S_IDLE) && start) ||
                        ((state == S_DONE) && continuous);
    assign busy       = (state == S_GATE) || (state == S_DONE);

    // Window sequencing; a low ena abandons whatever is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (!ena) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state <= start ? S_GATE : S_IDLE;
                S_GATE:  state <= (gate_cnt == '0) ? S_DONE : S_GATE;
                S_DONE:  state <= continuous ? S_GATE : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Edge and gate counters: clear on window entry, advance only during GATE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            gate_cnt <= '0;
            sat      <= 1'b0;
        end else if (ena && restart) begin
            edge_cnt <= '0;
            gate_cnt <= GATE_LOAD;
            sat      <= 1'b0;
        end else if (state == S_GATE) begin
            edge_cnt <= edge_next;
            sat      <= sat_next;
            if (gate_cnt != '0) gate_cnt <= gate_cnt - GW'(1);
        end
    end

    // Result registers update together with the valid strobe on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= ena && window_end;
            if (ena && window_end) begin
                count    <= edge_next;
                overflow <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench for clk_freq_meter. meas_in follows a pre-planned
// waveform, so each window's edge count is computed from the waveform
// itself when start is issued and queued for the monitor.
module tb_clk_freq_meter;

    localparam int G      = 16;
    localparam int W      = 3;
    localparam int MAXV   = (1 << W) - 1;
    localparam int WAVE_N = 8192;

    typedef struct {
        int cyc;
        int cnt;
        int ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, ena, meas_in, start, continuous;
    logic [W-1:0] count;
    logic         count_valid, overflow, busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   wave [WAVE_N];
    exp_t sbq[$];
    int   last_cnt = 0;
    int   last_ovf = 0;

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .meas_in(meas_in),
        .start(start), .continuous(continuous), .count(count),
        .count_valid(count_valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // meas_in for the coming edge cyc+1 is wave[cyc+1]
    initial begin
        meas_in = 1'b0;
        forever begin
            @(negedge clk);
            meas_in = (cyc + 1 < WAVE_N) ? wave[cyc + 1] : 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: an edge is seen at clock edge k when meas_in was high two
    // edges earlier and low three edges earlier. The window after start at
    // edge n covers edges n+1..n+G and is reported after edge n+G.
    function automatic exp_t model(input int n);
        exp_t e;
        int   raw = 0;
        for (int k = n + 1; k <= n + G; k++)
            if (wave[k-2] && !wave[k-3]) raw++;
        e.cyc = n + G;
        e.cnt = (raw > MAXV) ? MAXV : raw;
        e.ovf = (raw > MAXV) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Square wave of half-period h from edge cyc+2 onward
    task automatic fill(input int h, input int len);
        int base = cyc + 2;
        int ph   = $urandom_range(0, 2*h - 1);
        for (int i = 0; i < len; i++)
            if (base + i < WAVE_N) wave[base + i] = (((i + ph) / h) % 2) != 0;
    endtask

    task automatic issue_start(input bit push, output int n);
        @(negedge clk);
        start = 1'b1;
        n = cyc + 1;
        if (push) sbq.push_back(model(n));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL wait_done: timeout after %0d cycles, pending %0d", n, sbq.size());
        end
    endtask

    task automatic one_window(input int h);
        int n;
        fill(h, 3*G + 40);
        repeat (3) @(negedge clk);
        issue_start(1'b1, n);
        wait_done(4*G);
    endtask

    // Monitor: pop and compare on every valid; otherwise results must hold
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_cnt = 0;
                last_ovf = 0;
            end else if (count_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: count %0d at cyc %0d, none expected", count, cyc);
                    last_cnt = count;
                    last_ovf = overflow;
                end else begin
                    e = sbq.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("count", count, e.cnt);
                    chk("overflow", overflow, e.ovf);
                    last_cnt = e.cnt;
                    last_ovf = e.ovf;
                end
            end else begin
                checks++;
                if (count != last_cnt || overflow != last_ovf) begin
                    errors++;
                    $display("FAIL result_hold: count %0d ovf %0d, expected %0d %0d (cyc %0d)",
                             count, overflow, last_cnt, last_ovf, cyc);
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; continuous = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_valid", count_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        #2 rst_n = 1'b1;

        // Toggling input with start low: stays idle
        @(negedge clk);
        fill(1, 40);
        repeat (30) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
        end

        // Directed rates: nominal (period 4), max rate (period 2), period 8
        one_window(2);
        one_window(1);
        one_window(4);

        // Random rates
        repeat (6) one_window($urandom_range(1, 6));

        // Continuous: three back-to-back windows, period G+1
        fill($urandom_range(1, 4), 6*(G + 1) + 40);
        repeat (3) @(negedge clk);
        continuous = 1'b1;
        issue_start(1'b1, n);
        sbq.push_back(model(n + (G + 1)));
        sbq.push_back(model(n + 2*(G + 1)));
        while (cyc < n + 2*(G + 1) + 3) @(negedge clk);
        continuous = 1'b0;
        wait_done(6*G);
        repeat (30) @(negedge clk);
        chk("cont_busy_after", busy, 0);

        // start pulsed mid-window is ignored
        fill(3, 3*G + 40);
        repeat (3) @(negedge clk);
        issue_start(1'b1, n);
        repeat (5) @(negedge clk);
        chk("busy_in_gate", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4*G);

        // ena dropped mid-window: discarded, result held
        fill(1, 3*G + 40);
        repeat (3) @(negedge clk);
        issue_start(1'b0, n);
        repeat (6) @(negedge clk);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", busy, 0);
        ena = 1'b1;
        repeat (G + 10) @(negedge clk);
        chk("abort_count", count, last_cnt);
        chk("abort_overflow", overflow, last_ovf);

        // Make the held result non-zero before the reset test
        one_window(1);

        // Async reset between edges during GATE
        fill(2, 3*G + 40);
        repeat (3) @(negedge clk);
        issue_start(1'b0, n);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", count_valid, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_busy", busy, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        one_window(2);

        repeat (5) @(negedge clk);
        chk("queue_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Gated-window frequency counter for the clock-generator user project. It measures an asynchronous input (a generated clock looped back, or an external pin) against the system clock by counting rising edges of that input during a fixed window of `GATE_CYCLES` system clocks. The result is presented with a one-cycle valid strobe, so the bench and on-chip logic can check the generator's output frequency. It is the receiving end of the generator: the generator produces the clock, and this block reads it back.

## Interface
Parameters:
- `GATE_CYCLES`, default 1000, gate window length in `clk` cycles; legal range is 2 or more.
- `CNT_W`, default 16, width of the edge counter and of `count`.

Ports:
- `clk`, input, 1 bit, system clock. All state is in this domain.
- `rst_n`, input, 1 bit, reset. Asynchronous assert, active-low.
- `ena`, input, 1 bit, design enable. Low forces the block to IDLE.
- `meas_in`, input, 1 bit, signal under measurement. It is asynchronous to `clk`.
- `start`, input, 1 bit, level sampled each cycle. High in IDLE begins a measurement.
- `continuous`, input, 1 bit, sampled in DONE. When high, the next window starts immediately.
- `count`, output, `CNT_W` bits, edge count of the last completed window.
- `count_valid`, output, 1 bit, one-cycle pulse when `count` updates.
- `overflow`, output, 1 bit, set when the last completed window saturated.
- `busy`, output, 1 bit, high while in GATE or DONE.

## Operation
- **Input path.** `meas_in` passes through a 2-FF synchronizer (s1, s2) and then a delay register s3.
  - Edge detect is `rise = s2 & ~s3`.
  - All three registers reset to 0.
  - Edge detect runs in every state.
- **FSM states:** IDLE, GATE, DONE.
- **IDLE**
  - `busy` = 0.
  - If `ena` and `start` are both high, go to GATE next cycle. On entry the edge counter clears to 0, the gate counter loads `GATE_CYCLES-1`, and the saturation flag clears.
- **GATE**
  - `busy` = 1.
  - Each cycle with `rise` = 1, the edge counter increments.
  - At all-ones (2^`CNT_W`-1) the edge counter holds and the saturation flag sets.
  - The gate counter decrements each cycle. When it reads 0, go to DONE. The `rise` on that final cycle is still counted.
- **DONE** lasts one cycle.
  - `count` loads the edge counter, `overflow` loads the saturation flag, and `count_valid` = 1.
  - `rise` during DONE is not counted.
  - If `continuous` is high, go to GATE with the counters re-initialized as on IDLE exit. Otherwise go to IDLE.
- **start handling.** `start` is ignored in GATE and DONE. No queuing.
- **ena low**
  - In any state, the next state is IDLE.
  - A window in progress is discarded: no `count_valid`, and `count` and `overflow` keep their previous values.
- **Reset (asserted at any time)**
  - Outputs immediately: `count` = 0, `count_valid` = 0, `overflow` = 0, `busy` = 0.
  - FSM = IDLE; edge counter, gate counter and synchronizer = 0.
- **Measurable range.** The maximum measurable frequency is f_clk/2; `meas_in` must be high for at least one `clk` sample and low for at least one. Faster inputs alias and are not flagged.

## Timing
- `start` is sampled high at edge N; GATE occupies edges N+1 through N+`GATE_CYCLES`.
- DONE, and therefore `count_valid`, occurs at edge N+`GATE_CYCLES`+1.
- In continuous mode, back-to-back windows have a period of `GATE_CYCLES`+1 cycles.
- Synchronizer latency is 2 cycles to s2, so `rise` is asserted 2–3 cycles after a `meas_in` edge. Edges arriving in the 2 cycles before GATE entry can fall inside the window.
- Count resolution is ±1 edge.
- `count` and `overflow` are stable between `count_valid` pulses.

## Test plan
- **Reset values.** Reset asserted -> `count` = 0, `count_valid` = 0, `overflow` = 0, `busy` = 0. `meas_in` toggling with `start` low -> `busy` stays 0 and no `count_valid`.
- **Nominal count, `GATE_CYCLES`=100, `CNT_W`=16.** `meas_in` period 4 clk (2 high / 2 low), one-cycle `start` -> `count_valid` exactly 101 cycles after the `start` sample edge. `count` is 25 (±1 accepted), `overflow` = 0.
- **Maximum rate and saturation, `GATE_CYCLES`=16, `CNT_W`=3.**
  - `meas_in` period 2 clk -> raw count 8, so `count` = 7 and `overflow` = 1.
  - Repeat with period 8 clk -> `count` = 2 and `overflow` = 0; the saturation flag clears.
- **Continuous mode, `GATE_CYCLES`=10.** `continuous` = 1 and a single `start` -> `count_valid` pulses spaced exactly 11 cycles apart. Drop `continuous` -> after the next pulse, `busy` falls and no further pulses occur.
- **Abort and ignored start.**
  - Drop `ena` mid-GATE -> no `count_valid`, and `count` keeps the previous result.
  - Pulse `start` during GATE -> window length unchanged at `GATE_CYCLES`+1 cycles to `count_valid`.
- **Async reset mid-window.** Assert `rst_n` low between clock edges during GATE -> all outputs 0 immediately. After release, a new `start` yields a correct count.
